// File: rtl/pc_redirect_if.sv
// pc_redirect_if: fetch-stage redirect bus between the branch/jump sources
// and the PC redirect unit. Carries the request inputs and the PC outputs.
// Optional macro PC_REDIRECT_STATS_EN adds the REDIRECT_COUNT signal.
interface pc_redirect_if #(
  parameter int WIDTH = 32
);
  logic             BRANCH_TAKEN;
  logic [WIDTH-1:0] BRANCH_TARGET;
  logic             JUMP;
  logic [WIDTH-1:0] JUMP_TARGET;
  logic             STALL;
  logic [WIDTH-1:0] PC_OUT;
  logic [WIDTH-1:0] PC_PLUS4;
  logic             FLUSH;
  logic             PENDING;
`ifdef PC_REDIRECT_STATS_EN
  logic [15:0]      REDIRECT_COUNT;
`endif

  // Request side: drives redirects and stall, observes the PC
  modport master (
    output BRANCH_TAKEN, BRANCH_TARGET, JUMP, JUMP_TARGET, STALL,
`ifdef PC_REDIRECT_STATS_EN
    input  REDIRECT_COUNT,
`endif
    input  PC_OUT, PC_PLUS4, FLUSH, PENDING
  );

  // PC unit side: consumes requests, produces the PC
  modport slave (
    input  BRANCH_TAKEN, BRANCH_TARGET, JUMP, JUMP_TARGET, STALL,
`ifdef PC_REDIRECT_STATS_EN
    output REDIRECT_COUNT,
`endif
    output PC_OUT, PC_PLUS4, FLUSH, PENDING
  );
endinterface

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: program-counter register and redirect controller for the
// fetch stage. Picks the next PC (jump > branch > sequential), parks a redirect
// that arrives during a stall, and pulses FLUSH for one cycle when a redirect
// is applied. Optional macro PC_REDIRECT_STATS_EN adds a saturating
// 16-bit redirect counter on REDIRECT_COUNT.
module pc_redirect_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic          CLK,
  input  logic          RST,
  pc_redirect_if.slave  bus
);

  typedef enum logic {
    RUN,
    HOLD
  } state_t;

  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pendTarget_q, pendTarget_d;
  logic             flush_q, flush_d;
  logic             pending_q, pending_d;

  logic             redirectReq;
  logic [WIDTH-1:0] reqTarget;

  // Current request and its word-aligned target, jump taking priority
  always_comb begin
    redirectReq = bus.JUMP | bus.BRANCH_TAKEN;
    reqTarget   = (bus.JUMP ? bus.JUMP_TARGET : bus.BRANCH_TARGET) & ALIGN_MASK;
  end

  // Next-state logic: PC selection, pending capture and flush generation
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pendTarget_d = pendTarget_q;
    flush_d      = 1'b0;
    pending_d    = pending_q;

    unique case (state_q)
      RUN: begin
        if (!bus.STALL) begin
          if (redirectReq) begin
            pc_d    = reqTarget;
            flush_d = 1'b1;
          end else begin
            pc_d = pc_q + WIDTH'(4);
          end
        end else if (redirectReq) begin
          pendTarget_d = reqTarget;
          pending_d    = 1'b1;
          state_d      = HOLD;
        end
      end

      HOLD: begin
        if (bus.STALL) begin
          if (redirectReq) begin
            pendTarget_d = reqTarget;
          end
        end else begin
          pc_d      = redirectReq ? reqTarget : pendTarget_q;
          flush_d   = 1'b1;
          pending_d = 1'b0;
          state_d   = RUN;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State registers with synchronous reset that overrides every input
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= RUN;
      pc_q         <= RESET_PC;
      pendTarget_q <= '0;
      flush_q      <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pendTarget_q <= pendTarget_d;
      flush_q      <= flush_d;
      pending_q    <= pending_d;
    end
  end

  assign bus.PC_OUT   = pc_q;
  assign bus.PC_PLUS4 = pc_q + WIDTH'(4);
  assign bus.FLUSH    = flush_q;
  assign bus.PENDING  = pending_q;

`ifdef PC_REDIRECT_STATS_EN
  logic [15:0] count_q;

  // Saturating count of applied redirects (edges that set FLUSH)
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else if (flush_d && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign bus.REDIRECT_COUNT = count_q;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed vector table, a reset-in-HOLD sequence and a
// randomized run against a behavioural model of the PC redirect rules.
module tb_pc_redirect_unit;

  localparam int          W        = 32;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic CLK = 1'b0;
  logic RST;

  pc_redirect_if #(.WIDTH(W)) bus();

  pc_redirect_unit #(.WIDTH(W), .RESET_PC(RESET_PC)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        br;
    logic [31:0] bt;
    logic        j;
    logic [31:0] jt;
    logic        stall;
    logic [31:0] expPc;
    logic        expFlush;
    logic        expPending;
  } vec_t;

  vec_t vecs[$];
  int   assertCount = 0;
  int   failCount   = 0;

  function automatic void addVec(input logic rst, input logic br, input logic [31:0] bt,
                                 input logic j, input logic [31:0] jt, input logic stall,
                                 input logic [31:0] expPc, input logic expFlush,
                                 input logic expPending);
    vec_t v;
    v.rst = rst; v.br = br; v.bt = bt; v.j = j; v.jt = jt; v.stall = stall;
    v.expPc = expPc; v.expFlush = expFlush; v.expPending = expPending;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input logic rst, input logic br, input logic [31:0] bt,
                               input logic j, input logic [31:0] jt, input logic stall);
    RST               = rst;
    bus.BRANCH_TAKEN  = br;
    bus.BRANCH_TARGET = bt;
    bus.JUMP          = j;
    bus.JUMP_TARGET   = jt;
    bus.STALL         = stall;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [31:0] expPc,
                            input logic expFlush, input logic expPending);
    checkOutput({tag, " PC_OUT"}, bus.PC_OUT, expPc);
    checkOutput({tag, " PC_PLUS4"}, bus.PC_PLUS4, expPc + 32'd4);
    checkOutput({tag, " FLUSH"}, {31'd0, bus.FLUSH}, {31'd0, expFlush});
    checkOutput({tag, " PENDING"}, {31'd0, bus.PENDING}, {31'd0, expPending});
  endtask

  // Behavioural reference state for the random phase
  logic [31:0] mPc;
  logic        mFlush;
  logic        mPendValid;
  logic [31:0] mPendTarget;
  int          mCount;

  function automatic void modelStep(input logic rst, input logic br, input logic [31:0] bt,
                                    input logic j, input logic [31:0] jt, input logic stall);
    logic [31:0] tgt;
    tgt = (j ? jt : bt) & 32'hFFFF_FFFC;
    if (rst) begin
      mPc = RESET_PC; mFlush = 1'b0; mPendValid = 1'b0; mPendTarget = 32'h0; mCount = 0;
    end else if (stall) begin
      mFlush = 1'b0;
      if (j || br) begin
        mPendValid  = 1'b1;
        mPendTarget = tgt;
      end
    end else begin
      if (j || br) begin
        mPc = tgt; mFlush = 1'b1;
      end else if (mPendValid) begin
        mPc = mPendTarget; mFlush = 1'b1;
      end else begin
        mPc = mPc + 32'd4; mFlush = 1'b0;
      end
      mPendValid = 1'b0;
      if (mFlush && mCount < 65535) mCount++;
    end
  endfunction

  initial begin
    // reset then free-run
    addVec(1, 0, 0, 0, 0, 0, 32'h0,   0, 0);
    addVec(0, 0, 0, 0, 0, 0, 32'h4,   0, 0);
    addVec(0, 0, 0, 0, 0, 0, 32'h8,   0, 0);
    addVec(0, 0, 0, 0, 0, 0, 32'hC,   0, 0);
    // branch at PC 8
    addVec(1, 0, 0, 0, 0, 0, 32'h0,   0, 0);
    addVec(0, 0, 0, 0, 0, 0, 32'h4,   0, 0);
    addVec(0, 0, 0, 0, 0, 0, 32'h8,   0, 0);
    addVec(0, 1, 32'h40, 0, 0, 0, 32'h40, 1, 0);
    addVec(0, 0, 0, 0, 0, 0, 32'h44,  0, 0);
    // jump beats branch, then back-to-back redirect
    addVec(0, 1, 32'h40, 1, 32'h100, 0, 32'h100, 1, 0);
    addVec(0, 1, 32'h200, 0, 0, 0, 32'h200, 1, 0);
    addVec(0, 0, 0, 0, 0, 0, 32'h204, 0, 0);
    // branch during 3-cycle stall
    addVec(0, 1, 32'h80, 0, 0, 1, 32'h204, 0, 1);
    addVec(0, 0, 0, 0, 0, 1, 32'h204, 0, 1);
    addVec(0, 0, 0, 0, 0, 1, 32'h204, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 32'h80,  1, 0);
    addVec(0, 0, 0, 0, 0, 0, 32'h84,  0, 0);
    // unstall request overrides pending
    addVec(0, 0, 0, 1, 32'h300, 1, 32'h84, 0, 1);
    addVec(0, 1, 32'h500, 0, 0, 1, 32'h84, 0, 1);
    addVec(0, 1, 32'h600, 0, 0, 0, 32'h600, 1, 0);
    // latest pending request wins
    addVec(0, 1, 32'h700, 0, 0, 1, 32'h600, 0, 1);
    addVec(0, 0, 0, 1, 32'h800, 1, 32'h600, 0, 1);
    addVec(0, 0, 0, 0, 0, 1, 32'h600, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 32'h800, 1, 0);
    // stall without request stays in RUN
    addVec(0, 0, 0, 0, 0, 1, 32'h800, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 32'h804, 0, 0);
    // alignment and wrap
    addVec(0, 1, 32'h43, 0, 0, 0, 32'h40, 1, 0);
    addVec(0, 0, 0, 1, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFC, 1, 0);
    addVec(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    addVec(0, 0, 0, 0, 0, 0, 32'h4, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].br, vecs[i].bt, vecs[i].j, vecs[i].jt, vecs[i].stall);
      checkState($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expFlush, vecs[i].expPending);
    end

    // Reset while holding a pending redirect: the pending target must be lost
    applyStimulus(0, 1, 32'h80, 0, 0, 1);
    checkState("holdrst stall", 32'h4, 1'b0, 1'b1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkState("holdrst reset", RESET_PC, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkState($sformatf("holdrst fetch%0d", i), RESET_PC + 32'(4 * i), 1'b0, 1'b0);
    end

    // Randomized run against the behavioural model
    applyStimulus(1, 0, 0, 0, 0, 0);
    modelStep(1, 0, 0, 0, 0, 0);
    checkState("rand reset", mPc, mFlush, mPendValid);
    for (int i = 0; i < 3000; i++) begin
      logic        rst, br, j, stall;
      logic [31:0] bt, jt;
      rst   = ($urandom_range(0, 59) == 0);
      br    = ($urandom_range(0, 3) == 0);
      j     = ($urandom_range(0, 5) == 0);
      stall = ($urandom_range(0, 2) == 0);
      bt    = $urandom;
      jt    = $urandom;
      applyStimulus(rst, br, bt, j, jt, stall);
      modelStep(rst, br, bt, j, jt, stall);
      checkState($sformatf("rand%0d", i), mPc, mFlush, mPendValid);
`ifdef PC_REDIRECT_STATS_EN
      checkOutput($sformatf("rand%0d COUNT", i), {16'd0, bus.REDIRECT_COUNT}, 32'(mCount));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
